// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: the payload word carried by every stage
// and the depth of the processor pipeline built from pipe_stage_chain.
package lc3b_types;

    localparam int unsigned PIPE_STAGES = 4;

    // Packed payload; 64 bits total to match the chain's default WIDTH.
    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [31:0] ctrl;
    } lc3b_pipe_payload;

endpackage

// File: rtl/pipe_stage_chain_pkg.sv
// Common definitions for the payload-agnostic pipeline stage chain.
package pipe_stage_chain_pkg;

    localparam int unsigned RETIRE_W = 32;

    // Per-stage register action for one clock edge.
    typedef enum logic [1:0] {
        StgHold   = 2'd0,
        StgLoad   = 2'd1,
        StgBubble = 2'd2,
        StgFlush  = 2'd3
    } stage_op_e;

    // Flush beats a fill from upstream, which beats a plain departure.
    function automatic stage_op_e stage_op(input logic flush, input logic fill,
                                           input logic leave);
        stage_op_e op;
        if (flush) begin
            op = StgFlush;
        end else if (fill) begin
            op = StgLoad;
        end else if (leave) begin
            op = StgBubble;
        end else begin
            op = StgHold;
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_reg.sv
// One pipeline slot: valid bit plus payload, with load / clear / hold and
// asynchronous reset. Payload is zeroed whenever the slot becomes empty.
module pipe_stage_reg
    import pipe_stage_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  stage_op_e        op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next-state selection from the action decided by the chain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        unique case (op_i)
            StgHold: begin
            end
            StgLoad: begin
                valid_d = 1'b1;
                data_d  = data_i;
            end
            StgBubble, StgFlush: begin
                valid_d = 1'b0;
                data_d  = '0;
            end
            default: begin
            end
        endcase
    end

    // Slot register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES register slots with per-stage stall and flush.
// Bubbles collapse: an empty or flushed slot accepts even when a later one
// stalls. Occupancy and the retire count are registered.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned WIDTH  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stall_mask,
    input  logic [STAGES-1:0]           flush_mask,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*WIDTH-1:0]     stage_data,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [RETIRE_W-1:0]         retired
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid;
    logic [WIDTH-1:0]  data [STAGES];
    stage_op_e         op   [STAGES];

    logic [STAGES:0]   accept;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] valid_nxt;
    logic              entry;
    logic              retire;

    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [RETIRE_W-1:0] retired_q;

    // Handshake resolution from the consumer backwards, then per-slot actions.
    always_comb begin
        accept    = '0;
        move      = '0;
        valid_nxt = '0;
        occ_d     = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            op[i] = StgHold;
        end

        accept[STAGES] = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            move[i]   = valid[i] & ~stall_mask[i] & accept[i+1];
            // A flushed slot is emptied anyway, so it may swallow its upstream.
            accept[i] = ~valid[i] | move[i] | flush_mask[i];
        end

        entry = in_valid & accept[0];

        op[0] = stage_op(flush_mask[0], entry, move[0]);
        for (int i = 1; i < int'(STAGES); i++) begin
            op[i] = stage_op(flush_mask[i], move[i-1], move[i]);
        end

        for (int i = 0; i < int'(STAGES); i++) begin
            unique case (op[i])
                StgLoad: valid_nxt[i] = 1'b1;
                StgHold: valid_nxt[i] = valid[i];
                default: valid_nxt[i] = 1'b0;
            endcase
            occ_d = occ_d + OCC_W'(valid_nxt[i]);
        end
    end

    // Retire counts even when the last slot is flushed in the same cycle.
    assign retire = move[STAGES-1];

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        if (g == 0) begin : g_head
            assign d_in = in_data;
        end else begin : g_body
            assign d_in = data[g-1];
        end

        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .op_i    (op[g]),
            .data_i  (d_in),
            .valid_o (valid[g]),
            .data_o  (data[g])
        );

        assign stage_data[g*WIDTH +: WIDTH] = data[g];
    end

    // Occupancy and retire counters; the retire count wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q     <= '0;
            retired_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign in_ready    = accept[0];
    assign stage_valid = valid;
    assign out_valid   = valid[STAGES-1];
    assign out_data    = data[STAGES-1];
    assign occupancy   = occ_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (STAGES=4, WIDTH=16): directed
// scenarios plus randomized traffic against an item-level reference model.
module tb_pipe_stage_chain;

    localparam int unsigned STG = 4;
    localparam int unsigned W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [W-1:0]      in_data;
    logic              in_ready;
    logic [STG-1:0]    stall_mask;
    logic [STG-1:0]    flush_mask;
    logic [STG-1:0]    stage_valid;
    logic [STG*W-1:0]  stage_data;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              out_ready;
    logic [2:0]        occupancy;
    logic [31:0]       retired;

    pipe_stage_chain #(
        .STAGES (STG),
        .WIDTH  (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall_mask  (stall_mask),
        .flush_mask  (flush_mask),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .occupancy   (occupancy),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: which slots hold an item, and what it is.
    bit          m_v [STG];
    logic [W-1:0] m_d [STG];
    logic [31:0] m_ret;
    logic        last_rdy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_pack_data();
        logic [63:0] pk = '0;
        for (int i = 0; i < int'(STG); i++) pk[i*W +: W] = m_d[i];
        return pk;
    endfunction

    function automatic logic [3:0] m_pack_valid();
        logic [3:0] pv = '0;
        for (int i = 0; i < int'(STG); i++) pv[i] = m_v[i];
        return pv;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < int'(STG); i++) c += int'(m_v[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < int'(STG); i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_ret = '0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".valid"}, 64'(stage_valid), 64'(m_pack_valid()));
        check_eq({tag, ".data"}, stage_data, m_pack_data());
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(m_v[STG-1]));
        check_eq({tag, ".out_data"}, 64'(out_data), 64'(m_d[STG-1]));
        check_eq({tag, ".occupancy"}, 64'(occupancy), 64'(m_count()));
        check_eq({tag, ".retired"}, 64'(retired), 64'(m_ret));
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic [STG-1:0] st,
                         input logic [STG-1:0] fl, input logic ordy);
        bit           room [STG+1];
        bit           goes [STG];
        bit           nv   [STG];
        logic [W-1:0] nd   [STG];
        bit           fill;
        in_valid   = iv;
        in_data    = id;
        stall_mask = st;
        flush_mask = fl;
        out_ready  = ordy;
        #1;
        // An item advances when unstalled and the slot ahead will have room;
        // a slot has room if empty, vacating, or being flushed.
        room[STG] = ordy;
        for (int i = int'(STG) - 1; i >= 0; i--) begin
            goes[i] = m_v[i] && !st[i] && room[i+1];
            room[i] = !m_v[i] || goes[i] || fl[i];
        end
        check_eq("in_ready", 64'(in_ready), 64'(room[0]));
        last_rdy = in_ready;
        @(posedge clk);
        for (int i = 0; i < int'(STG); i++) begin
            fill = (i == 0) ? (iv && room[0]) : goes[i-1];
            if (fl[i]) begin
                nv[i] = 1'b0; nd[i] = '0;
            end else if (fill) begin
                nv[i] = 1'b1; nd[i] = (i == 0) ? id : m_d[i-1];
            end else if (goes[i]) begin
                nv[i] = 1'b0; nd[i] = '0;
            end else begin
                nv[i] = m_v[i]; nd[i] = m_d[i];
            end
        end
        if (goes[STG-1]) m_ret = m_ret + 32'd1;
        for (int i = 0; i < int'(STG); i++) begin
            m_v[i] = nv[i];
            m_d[i] = nd[i];
        end
        #1;
        check_state("cycle");
        @(negedge clk);
    endtask

    // Reset asserted between edges: outputs must clear before any edge.
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        #1;
        m_clear();
        check_eq("rst.valid", 64'(stage_valid), 64'h0);
        check_eq("rst.data", stage_data, 64'h0);
        check_eq("rst.out_valid", 64'(out_valid), 64'h0);
        check_eq("rst.occupancy", 64'(occupancy), 64'h0);
        check_eq("rst.retired", 64'(retired), 64'h0);
        check_eq("rst.in_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        check_state("rst_entry_ignored");
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [63:0] snap;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        stall_mask = '0;
        flush_mask = '0;
        out_ready  = 1'b1;
        last_rdy   = 1'b0;
        m_clear();
        @(negedge clk);
        do_reset();

        // Streaming: three back-to-back entries, four-cycle latency.
        cycle(1'b1, 16'h1111, 4'b0000, 4'b0000, 1'b1);
        cycle(1'b1, 16'h2222, 4'b0000, 4'b0000, 1'b1);
        cycle(1'b1, 16'h3333, 4'b0000, 4'b0000, 1'b1);
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        check_eq("stream.first_out", 64'({out_valid, out_data}), 64'({1'b1, 16'h1111}));
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        check_eq("stream.second_out", 64'(out_data), 64'h2222);
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        check_eq("stream.third_out", 64'(out_data), 64'h3333);
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        check_eq("stream.retired", 64'(retired), 64'd3);
        check_eq("stream.occ_empty", 64'(occupancy), 64'd0);

        // Bubble collapse with the last stage stalled.
        cycle(1'b1, 16'hAAAA, 4'b0000, 4'b0000, 1'b1);
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        cycle(1'b1, 16'hBBBB, 4'b0000, 4'b0000, 1'b1);
        cycle(1'b0, 16'h0000, 4'b1000, 4'b0000, 1'b1);
        check_eq("bubble.setup_valid", 64'(stage_valid), 64'b1010);
        check_eq("bubble.setup_occ", 64'(occupancy), 64'd2);
        cycle(1'b1, 16'hCCCC, 4'b1000, 4'b0000, 1'b1);
        check_eq("bubble.in_ready", 64'(last_rdy), 64'h1);
        check_eq("bubble.valid", 64'(stage_valid), 64'b1101);
        check_eq("bubble.occ", 64'(occupancy), 64'd3);
        check_eq("bubble.held", 64'(out_data), 64'hAAAA);

        // Fill the remaining hole, then back-pressure for three cycles.
        cycle(1'b1, 16'hDDDD, 4'b0000, 4'b0000, 1'b0);
        check_eq("bp.full", 64'(stage_valid), 64'b1111);
        snap = stage_data;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 16'hEEEE, 4'b0000, 4'b0000, 1'b0);
            check_eq("bp.in_ready", 64'(last_rdy), 64'h0);
            check_eq("bp.data_held", stage_data, snap);
            check_eq("bp.retired_held", 64'(retired), 64'd3);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
            check_eq("bp.drain_retired", 64'(retired), 64'(4 + k));
        end

        // Flush of the two front stages while an entry is offered.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 16'(16'h5000 + k), 4'b0000, 4'b0000, 1'b0);
        end
        check_eq("flush.full", 64'(stage_valid), 64'b1111);
        cycle(1'b1, 16'h9999, 4'b0000, 4'b0011, 1'b1);
        check_eq("flush.valid", 64'(stage_valid), 64'b1100);
        check_eq("flush.front_zero", 64'(stage_data[31:0]), 64'h0);
        check_eq("flush.out_data", 64'(out_data), 64'h5001);
        check_eq("flush.retired", 64'(retired), 64'd8);

        // Randomized traffic with occasional stalls and flushes.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  4'($urandom) & 4'($urandom) & 4'($urandom),
                  4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end

        // Mid-operation reset with three items in flight and five retired.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 16'(16'h0100 + k), 4'b0000, 4'b0000, 1'b1);
        end
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        check_eq("midrst.occ_before", 64'(occupancy), 64'd3);
        check_eq("midrst.retired_before", 64'(retired), 64'd5);
        do_reset();

        // First entry lands on the first edge after reset release.
        cycle(1'b1, 16'h7777, 4'b0000, 4'b0000, 1'b1);
        check_eq("post_rst.first_entry", 64'(stage_valid), 64'b0001);

        // Retire counter wrap from a preloaded all-ones value.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
        end
        check_eq("wrap.item_at_tail", 64'(stage_valid), 64'b1000);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        m_ret = 32'hFFFF_FFFF;
        check_eq("wrap.preload", 64'(retired), 64'hFFFF_FFFF);
        cycle(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        check_eq("wrap.retired_zero", 64'(retired), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter STAGES, default 4: number of register stages, legal range 2..8.
REQ-002 SHALL have parameter WIDTH, default 64: payload bits per stage (IR, PC and control word packed).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: entry payload present.
REQ-006 SHALL have port in_data, input, WIDTH bits: entry payload.
REQ-007 SHALL have port in_ready, output, 1 bit: stage 0 accepts this cycle.
REQ-008 SHALL have port stall_mask, input, STAGES bits: bit i holds stage i.
REQ-009 SHALL have port flush_mask, input, STAGES bits: bit i kills stage i.
REQ-010 SHALL have port stage_valid, output, STAGES bits: per-stage valid.
REQ-011 SHALL have port stage_data, output, STAGES*WIDTH bits: stage i occupies bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid, output, 1 bit: equals stage_valid[STAGES-1].
REQ-013 SHALL have port out_data, output, WIDTH bits: equals stage STAGES-1 payload.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer retires the last stage.
REQ-015 SHALL have port occupancy, output, $clog2(STAGES+1) bits: registered count of valid stages.
REQ-016 SHALL have port retired, output, 32 bits: count of retire handshakes.

Function
REQ-017 SHALL define move[i] = valid[i] & ~stall_mask[i] & accept[i+1], where accept[STAGES] = out_ready.
REQ-018 SHALL define accept[i] = ~valid[i] | move[i] for i in 0..STAGES-1, making bubbles collapse: an empty stage fills even while a downstream stage stalls.
REQ-019 SHALL drive in_ready = accept[0] combinationally; entry occurs when in_valid & in_ready.
REQ-020 SHALL load stage i+1 with stage i payload and valid=1 when move[i]; SHALL load stage 0 from in_data on entry.
REQ-021 SHALL clear valid[i] when stage i moves and receives nothing (bubble insertion).
REQ-022 SHALL hold stage i unchanged when valid[i] & ~move[i].
REQ-023 SHALL give flush_mask[i] priority over hold, move-in and entry: next-cycle valid[i]=0 and data[i]=0.
REQ-024 SHALL still count as retired a last stage that retires (out_valid & out_ready) in the same cycle that flush_mask[STAGES-1] is set.
REQ-025 SHALL make a flushed stage i still count as accepting, so that stage i-1 may move into it and be discarded.
REQ-026 SHALL give stall_mask[STAGES-1]=1 priority over out_ready: no retire occurs.
REQ-027 SHALL have a latency of STAGES cycles from entry to out_valid when there are no stalls and out_ready=1; throughput SHALL be one item per cycle.
REQ-028 SHALL update occupancy to the post-edge popcount of valid, registered and never combinational from inputs.
REQ-029 SHALL increment retired by 1 on each retire handshake; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 SHALL drive out_valid = 0 and stage_data of invalid stages = 0 after reset or flush.

Reset
REQ-031 SHALL, while reset=1, asynchronously force all valid=0, all stage data=0, occupancy=0 and retired=0.
REQ-032 SHALL hold in_ready=1 during reset, unless stall_mask[0] is set with a valid stage 0.
REQ-033 SHALL ignore entry during reset.
REQ-034 SHALL drop in-flight items on reset asserted mid-operation, with no partial retire.
REQ-035 SHALL make the first entry possible on the first rising clk edge after reset deasserts.

Structure
REQ-036 SHALL have lc3b_types provide the lc3b_pipe_payload packed struct (IR, PC, control word) and the PIPE_STAGES constant; pipe_stage_chain itself SHALL remain payload-agnostic.
REQ-037 SHALL instantiate one sub-module pipe_stage_reg per stage (valid+data register with load, clear, async reset); the chain SHALL hold the accept/move logic and counters.
REQ-038 SHALL contain no latches and no combinational path from out_ready to stage_data.

Verification (STAGES=4, WIDTH=16)
REQ-039 SHALL cover streaming: enter 0x1111, 0x2222, 0x3333 on consecutive cycles with out_ready=1 -> out_data 0x1111 on cycle 4, then 0x2222 and 0x3333; retired=3; occupancy returns to 0.
REQ-040 SHALL cover bubble collapse: stages 3,1 valid, stall_mask=0b1000 -> stage 1 advances to 2, in_ready=1, stage 3 held, occupancy stays 2 with a new entry into stage 0 making 3.
REQ-041 SHALL cover flush vs entry: full pipe, flush_mask=0b0011 with in_valid=1 -> next cycle stage_valid=0b1100, data of stages 0 and 1 = 0, entered item discarded.
REQ-042 SHALL cover back-pressure: full pipe, out_ready=0 for 3 cycles -> in_ready=0, stage_data unchanged, retired unchanged; then out_ready=1 -> one retire per cycle.
REQ-043 SHALL cover mid-operation reset: occupancy=3 and retired=5, assert reset between edges -> outputs zero immediately, before the next clk edge.
REQ-044 SHALL cover counter wrap: preload retired to 0xFFFFFFFF via forced state, then one retire -> retired=0x00000000.
